// File: rtl/sipo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sipo_pkg : shared types for the serial-in parallel-out deserializer  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package sipo_pkg;

  typedef enum logic [0:0] {
    SIPO_IDLE  = 1'b0,
    SIPO_SHIFT = 1'b1
  } sipo_state_t;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sipo_out_reg : one-entry holding register with valid/ready handshake |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module sipo_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  free
);

  // A consumer handshake on this edge makes room for a same-edge load.
  assign free = !valid_out || ready_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load && free) begin
      data_out  <= load_data;
      valid_out <= 1'b1;
    end else if (ready_in && valid_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule : sipo_out_reg
`default_nettype wire

// File: rtl/sipo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sipo     : LSB-first serial-in, parallel-out deserializer            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sipo
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ser_data_in,
  input  logic                  ser_valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  sipo_state_t           state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  complete;
  logic                  free;

  assign next_word = {ser_data_in, shift_reg[DATA_WIDTH-1:1]};
  assign complete  = (state == SIPO_SHIFT) && ser_valid_in && (bit_cnt == LAST_BIT);
  assign busy      = (state == SIPO_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SIPO_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= complete && !free;
      frame_err <= (state == SIPO_SHIFT) && !ser_valid_in;
      if (state == SIPO_IDLE) begin
        if (ser_valid_in) begin
          shift_reg <= next_word;
          bit_cnt   <= CNT_W'(1);
          state     <= SIPO_SHIFT;
        end
      end else begin
        if (ser_valid_in) begin
          shift_reg <= next_word;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= SIPO_IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end else begin
          // Truncated frame: leftover shift_reg bits get overwritten by the next frame.
          bit_cnt <= '0;
          state   <= SIPO_IDLE;
        end
      end
    end
  end

  sipo_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (complete),
    .load_data(next_word),
    .ready_in (ready_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .free     (free)
  );

endmodule : sipo
`default_nettype wire
